// File: rtl/scan_selector.sv
// scan_selector: registered N_CH:1 channel selector with a manual mode and a timed auto-scan mode.
// Optional macro SCAN_SEL_MASK_EN adds ch_mask so that auto-scan skips disabled channels.
module scan_selector #(
    parameter  int N_CH  = 4,
    parameter  int W     = 8,
    parameter  int DWELL = 25000000,
    localparam int SELW  = $clog2(N_CH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_CH*W-1:0]   din,
    input  logic                mode,
    input  logic [SELW-1:0]     man_sel,
    input  logic                step,
    input  logic                pause,
`ifdef SCAN_SEL_MASK_EN
    input  logic [N_CH-1:0]     ch_mask,
`endif
    output logic [W-1:0]        y,
    output logic [SELW-1:0]     sel,
    output logic                wrap,
    output logic                y_stb
);

    localparam int              CW       = $clog2(DWELL);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DWELL - 1);
    localparam logic [SELW-1:0] SEL_MAX  = SELW'(N_CH - 1);

    logic [CW-1:0]   r_cnt;
    logic            r_sel_chg;
    logic [W-1:0]    w_ch [N_CH];
    logic [N_CH-1:0] w_mask;
    logic [SELW-1:0] w_next;
    logic            w_found;
    logic [SELW-1:0] w_man;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign w_ch[i] = din[i*W +: W];
    end

`ifdef SCAN_SEL_MASK_EN
    assign w_mask = ch_mask;
`else
    assign w_mask = '1;
`endif

    assign w_man = (int'(man_sel) >= N_CH) ? SEL_MAX : man_sel;

    // Search upward from sel+1, wrapping; the last candidate is sel itself.
    always_comb begin : next_sel
        int idx;
        idx     = 0;
        w_next  = sel;
        w_found = 1'b0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = int'(sel) + k;
            if (idx >= N_CH) begin
                idx = idx - N_CH;
            end
            if (!w_found && w_mask[SELW'(idx)]) begin
                w_next  = SELW'(idx);
                w_found = 1'b1;
            end
        end
    end

    // r_sel_chg marks a sel change so y_stb fires on the edge y first picks it up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_sel_chg <= 1'b0;
            sel       <= '0;
            y         <= '0;
            wrap      <= 1'b0;
            y_stb     <= 1'b0;
        end else begin
            y         <= w_ch[sel];
            y_stb     <= r_sel_chg;
            wrap      <= 1'b0;
            r_sel_chg <= 1'b0;
            if (!mode) begin
                sel       <= w_man;
                r_cnt     <= '0;
                r_sel_chg <= (w_man != sel);
            end else if (!pause && w_found) begin
                if (step || (r_cnt == CNT_LAST)) begin
                    sel       <= w_next;
                    r_cnt     <= '0;
                    wrap      <= (w_next <= sel);
                    r_sel_chg <= (w_next != sel);
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_scan_selector.sv
// Directed bench for scan_selector: auto scan, step/pause, manual clamp, din-only change,
// async reset pulse and mode switching; mask scenarios are built in with SCAN_SEL_MASK_EN.
module tb_scan_selector;

    localparam int N_CH  = 4;
    localparam int W     = 8;
    localparam int DWELL = 4;
    localparam int SELW  = 2;

    logic              clk = 1'b0;
    logic              rst;

    logic [N_CH*W-1:0] din0;
    logic              mode0, step0, pause0;
    logic [SELW-1:0]   man_sel0;
    logic [W-1:0]      y0;
    logic [SELW-1:0]   sel0;
    logic              wrap0, y_stb0;

    logic [3*W-1:0]    din1;
    logic              mode1;
    logic [1:0]        man_sel1;
    logic [W-1:0]      y1;
    logic [1:0]        sel1;
    logic              wrap1, y_stb1;

`ifdef SCAN_SEL_MASK_EN
    logic [3:0]        ch_mask0;
    logic [2:0]        ch_mask1;
`endif

    int                checks = 0;
    int                errors = 0;
    logic [W-1:0]      exp_q[$];
    logic [W-1:0]      exp_sel;
    logic [W-1:0]      y_tab [4];
    logic [15:0]       stb_tab;
    logic [15:0]       wrap_tab;

    scan_selector #(.N_CH(N_CH), .W(W), .DWELL(DWELL)) u0 (
        .clk     (clk),
        .rst     (rst),
        .din     (din0),
        .mode    (mode0),
        .man_sel (man_sel0),
        .step    (step0),
        .pause   (pause0),
`ifdef SCAN_SEL_MASK_EN
        .ch_mask (ch_mask0),
`endif
        .y       (y0),
        .sel     (sel0),
        .wrap    (wrap0),
        .y_stb   (y_stb0)
    );

    scan_selector #(.N_CH(3), .W(W), .DWELL(DWELL)) u1 (
        .clk     (clk),
        .rst     (rst),
        .din     (din1),
        .mode    (mode1),
        .man_sel (man_sel1),
        .step    (1'b0),
        .pause   (1'b0),
`ifdef SCAN_SEL_MASK_EN
        .ch_mask (ch_mask1),
`endif
        .y       (y1),
        .sel     (sel1),
        .wrap    (wrap1),
        .y_stb   (y_stb1)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // driver helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // scoreboard check
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst      = 1'b1;
        din0     = 32'h44332211;
        mode0    = 1'b1;
        step0    = 1'b0;
        pause0   = 1'b0;
        man_sel0 = '0;
        din1     = 24'h332211;
        mode1    = 1'b0;
        man_sel1 = 2'd3;
`ifdef SCAN_SEL_MASK_EN
        ch_mask0 = 4'hF;
        ch_mask1 = 3'h7;
`endif
        y_tab    = '{8'h11, 8'h22, 8'h33, 8'h44};
        stb_tab  = 16'b0001_0001_0001_0000;
        wrap_tab = 16'b1000_0000_0000_0000;
        exp_q    = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd2,
                     8'd2, 8'd2, 8'd2, 8'd3, 8'd3, 8'd3, 8'd3, 8'd0};

        #2;
        chk("rst_y",     y0,     0);
        chk("rst_sel",   sel0,   0);
        chk("rst_wrap",  wrap0,  0);
        chk("rst_stb",   y_stb0, 0);
        chk("rst_sel_n3", sel1,  0);
        @(negedge clk);
        rst = 1'b0;

        // free-running auto scan from reset
        for (int e = 1; e <= 16; e++) begin
            tick();
            exp_sel = exp_q.pop_front();
            chk("auto_sel",  sel0,   exp_sel);
            chk("auto_y",    y0,     y_tab[(e-1)/4]);
            chk("auto_stb",  y_stb0, stb_tab[e-1]);
            chk("auto_wrap", wrap0,  wrap_tab[e-1]);
            if (e == 2) begin
                chk("n3_clamp_sel", sel1,   2);
                chk("n3_clamp_y",   y1,     8'h33);
                chk("n3_clamp_stb", y_stb1, 1);
            end
        end
        tick();
        chk("wrap_after_sel", sel0,   0);
        chk("wrap_after_y",   y0,     8'h11);
        chk("wrap_after_stb", y_stb0, 1);
        chk("wrap_clear",     wrap0,  0);

        // step at cnt=1, plus manual reselect on the N_CH=3 instance
        step0    = 1'b1;
        man_sel1 = 2'd1;
        tick();
        step0 = 1'b0;
        chk("step_sel",   sel0,   1);
        chk("step_wrap",  wrap0,  0);
        chk("step_stb0",  y_stb0, 0);
        chk("n3_sel1",    sel1,   1);
        chk("n3_y_old",   y1,     8'h33);
        chk("n3_stb_lag", y_stb1, 0);
        tick();
        chk("step_y",    y0,     8'h22);
        chk("step_stb",  y_stb0, 1);
        chk("n3_y_new",  y1,     8'h22);
        chk("n3_stb",    y_stb1, 1);
        chk("n3_wrap",   wrap1,  0);
        tick();
        chk("n3_stb_one", y_stb1, 0);
        chk("dwell_sel_a", sel0, 1);
        tick();
        chk("dwell_sel_b", sel0, 1);
        tick();
        chk("dwell_adv", sel0, 2);

        // pause holds everything and overrides step
        pause0 = 1'b1;
        step0  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("pause_sel",  sel0,   2);
            chk("pause_y",    y0,     8'h33);
            chk("pause_wrap", wrap0,  0);
            chk("pause_stb",  y_stb0, (k == 0) ? 1 : 0);
        end
        pause0 = 1'b0;
        step0  = 1'b0;

        // data change without sel change
        din0 = 32'h445A2211;
        tick();
        chk("din_y",   y0,     8'h5A);
        chk("din_stb", y_stb0, 0);
        chk("din_sel", sel0,   2);
        tick();
        chk("pre_rst_sel", sel0, 2);

        // async reset pulse between edges at sel=2, cnt=2
        #2;
        rst = 1'b1;
        #1;
        chk("arst_y",    y0,     0);
        chk("arst_sel",  sel0,   0);
        chk("arst_wrap", wrap0,  0);
        chk("arst_stb",  y_stb0, 0);
        #2;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("post_rst_sel", sel0, (k == 3) ? 1 : 0);
            chk("post_rst_y",   y0,   8'h11);
        end

        // auto -> manual -> auto
        mode0    = 1'b0;
        man_sel0 = 2'd3;
        tick();
        chk("man_sel",  sel0,   3);
        chk("man_wrap", wrap0,  0);
        chk("man_y",    y0,     8'h22);
        tick();
        chk("man_y_new", y0,     8'h44);
        chk("man_stb",   y_stb0, 1);
        mode0 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("resume_sel",  sel0,  (k == 3) ? 0 : 3);
            chk("resume_wrap", wrap0, (k == 3) ? 1 : 0);
        end

`ifdef SCAN_SEL_MASK_EN
        exp_q    = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd3,
                     8'd3, 8'd3, 8'd3, 8'd1, 8'd1, 8'd1, 8'd1, 8'd3};
        wrap_tab = 16'b0000_1000_0000_0000;
        ch_mask0 = 4'b1010;
        for (int e = 1; e <= 16; e++) begin
            tick();
            exp_sel = exp_q.pop_front();
            chk("mask_sel",  sel0,  exp_sel);
            chk("mask_wrap", wrap0, wrap_tab[e-1]);
        end
        ch_mask0 = 4'b0000;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("mask0_sel",  sel0,   3);
            chk("mask0_wrap", wrap0,  0);
            chk("mask0_stb",  y_stb0, (k == 0) ? 1 : 0);
        end
        ch_mask0 = 4'b1000;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("mask1_sel",  sel0,   3);
            chk("mask1_wrap", wrap0,  (k == 3) ? 1 : 0);
            chk("mask1_stb",  y_stb0, 0);
        end
        tick();
        chk("mask1_stb_after", y_stb0, 0);
`endif

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
